// File: rtl/syst_pkg.sv
`default_nettype none
// ============================================================================
// Module   : syst_pkg
// Purpose  : Shared constants and types for the systolic-array PE family.
//            Holds default operand/accumulator widths, the PE state
//            encoding and the bit positions inside the sticky error vector.
// Revision : 1.0 - initial release
// ============================================================================
package syst_pkg;

  // Default geometry of a PE
  localparam int DAT_WIDTH_DEF = 16;
  localparam int ACC_WIDTH_DEF = 40;
  localparam int K_MAX_DEF     = 256;

  // Positions inside o_err
  localparam int ERR_SKEW = 0;
  localparam int ERR_OVF  = 1;

  // Output-stationary PE run state
  typedef enum logic [0:0] {
    PE_IDLE = 1'b0,
    PE_ACC  = 1'b1
  } pe_state_e;

endpackage : syst_pkg
`default_nettype wire

// File: rtl/syst_pe_mac.sv
`default_nettype none
// ============================================================================
// Module   : syst_pe_mac
// Purpose  : Combinational signed multiply-add. Computes
//            o_sum = i_acc + sext(i_a * i_b). The full DAT x DAT product is
//            formed and sign-extended to ACC_WIDTH before the add.
// Config   : SYST_PE_SAT_EN defined   -> add saturates to the signed
//                                         ACC_WIDTH range
//            SYST_PE_SAT_EN undefined -> add wraps modulo 2^ACC_WIDTH
// Ports    : i_acc  [ACC_WIDTH] running sum, signed
//            i_a    [DAT_WIDTH] operand A, signed
//            i_b    [DAT_WIDTH] operand B, signed
//            o_sum  [ACC_WIDTH] i_acc + i_a*i_b, signed
// Revision : 1.0 - initial release
// ============================================================================
module syst_pe_mac #(
  parameter int DAT_WIDTH = 16,
  parameter int ACC_WIDTH = 40
) (
  input  logic signed [ACC_WIDTH-1:0] i_acc,
  input  logic signed [DAT_WIDTH-1:0] i_a,
  input  logic signed [DAT_WIDTH-1:0] i_b,
  output logic signed [ACC_WIDTH-1:0] o_sum
);

  localparam int c_PW = 2 * DAT_WIDTH;

  logic signed [c_PW-1:0]      w_a_ext;
  logic signed [c_PW-1:0]      w_b_ext;
  logic signed [c_PW-1:0]      w_prod;
  logic signed [ACC_WIDTH-1:0] w_prod_ext;
  logic signed [ACC_WIDTH-1:0] w_sum_wrap;

  // Size casts of signed values sign-extend, so the product is exact in
  // 2*DAT_WIDTH bits and then widened to the accumulator width.
  assign w_a_ext    = c_PW'(i_a);
  assign w_b_ext    = c_PW'(i_b);
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_prod_ext = ACC_WIDTH'(w_prod);
  assign w_sum_wrap = i_acc + w_prod_ext;

`ifdef SYST_PE_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] c_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] c_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic w_ovf;

  // Signed overflow: both addends share a sign the result does not have.
  assign w_ovf = (i_acc[ACC_WIDTH-1] == w_prod_ext[ACC_WIDTH-1]) &&
                 (w_sum_wrap[ACC_WIDTH-1] != i_acc[ACC_WIDTH-1]);

  assign o_sum = w_ovf ? (i_acc[ACC_WIDTH-1] ? c_MIN : c_MAX) : w_sum_wrap;
`else
  assign o_sum = w_sum_wrap;
`endif

endmodule : syst_pe_mac
`default_nettype wire

// File: rtl/syst_pe.sv
`default_nettype none
// ============================================================================
// Module   : syst_pe
// Purpose  : Output-stationary systolic-array processing element. Forwards
//            A right and B down with one cycle of latency, accumulates the
//            signed A*B products of a programmable-length dot product and
//            presents each finished sum on a ready/valid result port.
// Config   : SYST_PE_SAT_EN (in syst_pe_mac) selects saturating instead of
//            wrapping accumulation.
// Ports    : clk, rst      clock, synchronous active-high reset
//            i_len         dot-product length, sampled on a run's first beat
//            i_a_vld/i_a   A operand from the left (row skew)
//            i_b_vld/i_b   B operand from the top (column skew)
//            o_a_vld/o_a   A forwarded to the right neighbour
//            o_b_vld/o_b   B forwarded to the lower neighbour
//            o_res_vld/o_res/i_res_rdy  result handshake
//            o_err         sticky errors [0] skew, [1] result dropped
// Revision : 1.0 - initial release
// ============================================================================
module syst_pe
  import syst_pkg::*;
#(
  parameter  int DAT_WIDTH = DAT_WIDTH_DEF,
  parameter  int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter  int K_MAX     = K_MAX_DEF,
  localparam int CNT_WIDTH = $clog2(K_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_WIDTH-1:0] i_len,
  input  logic                 i_a_vld,
  input  logic [DAT_WIDTH-1:0] i_a,
  input  logic                 i_b_vld,
  input  logic [DAT_WIDTH-1:0] i_b,
  output logic                 o_a_vld,
  output logic [DAT_WIDTH-1:0] o_a,
  output logic                 o_b_vld,
  output logic [DAT_WIDTH-1:0] o_b,
  output logic                 o_res_vld,
  output logic [ACC_WIDTH-1:0] o_res,
  input  logic                 i_res_rdy,
  output logic [1:0]           o_err
);

  localparam logic [CNT_WIDTH-1:0] c_K_MAX = CNT_WIDTH'(K_MAX);
  localparam logic [CNT_WIDTH-1:0] c_ONE   = CNT_WIDTH'(1);

  pe_state_e             r_state;
  logic [CNT_WIDTH-1:0]  r_len;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [ACC_WIDTH-1:0]  r_res;
  logic                  r_res_vld;
  logic [1:0]            r_err;
  logic                  r_a_vld;
  logic [DAT_WIDTH-1:0]  r_a;
  logic                  r_b_vld;
  logic [DAT_WIDTH-1:0]  r_b;

  logic                  w_beat;
  logic                  w_skew;
  logic                  w_idle;
  logic                  w_done;
  logic [CNT_WIDTH-1:0]  w_len_sel;
  logic [CNT_WIDTH-1:0]  w_cnt_inc;
  logic [ACC_WIDTH-1:0]  w_acc_in;
  logic [ACC_WIDTH-1:0]  w_sum;

  assign w_beat    = i_a_vld & i_b_vld;
  assign w_skew    = i_a_vld ^ i_b_vld;
  assign w_idle    = (r_state == PE_IDLE);
  assign w_cnt_inc = r_cnt + c_ONE;

  // Length 0 means a single-beat run; anything above K_MAX is clamped.
  always_comb begin
    w_len_sel = i_len;
    if (i_len == '0) begin
      w_len_sel = c_ONE;
    end else if (i_len > c_K_MAX) begin
      w_len_sel = c_K_MAX;
    end
  end

  // The first beat of a run starts from zero so acc becomes the product.
  assign w_acc_in = w_idle ? '0 : r_acc;

  assign w_done = w_beat & (w_idle ? (w_len_sel == c_ONE)
                                   : (w_cnt_inc == r_len));

  syst_pe_mac #(
    .DAT_WIDTH (DAT_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .i_acc (w_acc_in),
    .i_a   (i_a),
    .i_b   (i_b),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= PE_IDLE;
      r_len     <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_res     <= '0;
      r_res_vld <= 1'b0;
      r_err     <= '0;
      r_a_vld   <= 1'b0;
      r_a       <= '0;
      r_b_vld   <= 1'b0;
      r_b       <= '0;
    end else begin
      // Forwarding ignores result backpressure entirely.
      r_a_vld <= i_a_vld;
      r_a     <= i_a;
      r_b_vld <= i_b_vld;
      r_b     <= i_b;

      if (w_skew) begin
        r_err[ERR_SKEW] <= 1'b1;
      end

      if (w_beat) begin
        r_acc <= w_sum;
        if (w_idle) begin
          r_len <= w_len_sel;
          r_cnt <= c_ONE;
          if (w_len_sel != c_ONE) begin
            r_state <= PE_ACC;
          end
        end else begin
          r_cnt <= w_cnt_inc;
          if (w_done) begin
            r_state <= PE_IDLE;
          end
        end
      end

      // A completion wins over a pop; a completion into a full, stalled
      // result register is dropped and flagged.
      if (w_done) begin
        if (r_res_vld && !i_res_rdy) begin
          r_err[ERR_OVF] <= 1'b1;
        end else begin
          r_res     <= w_sum;
          r_res_vld <= 1'b1;
        end
      end else if (r_res_vld && i_res_rdy) begin
        r_res_vld <= 1'b0;
      end
    end
  end

  assign o_a_vld   = r_a_vld;
  assign o_a       = r_a;
  assign o_b_vld   = r_b_vld;
  assign o_b       = r_b;
  assign o_res_vld = r_res_vld;
  assign o_res     = r_res;
  assign o_err     = r_err;

endmodule : syst_pe
`default_nettype wire

// File: tb/tb_syst_pe.sv
`default_nettype none
// ============================================================================
// Module   : tb_syst_pe
// Purpose  : Self-checking bench for syst_pe. Expected results are queued
//            when a run's last beat is driven and compared when the DUT
//            hands the result over (o_res_vld & i_res_rdy). A second
//            instance with a 32-bit accumulator covers wrap / saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_syst_pe;

  localparam int DW = 16;
  localparam int AW = 40;
  localparam int KM = 256;
  localparam int CW = $clog2(KM + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CW-1:0] i_len = '0;
  logic          i_a_vld = 1'b0;
  logic [DW-1:0] i_a = '0;
  logic          i_b_vld = 1'b0;
  logic [DW-1:0] i_b = '0;
  logic          i_res_rdy = 1'b0;

  logic          o_a_vld, o_b_vld, o_res_vld;
  logic [DW-1:0] o_a, o_b;
  logic [AW-1:0] o_res;
  logic [1:0]    o_err;

  logic          s_a_vld, s_b_vld, s_res_vld;
  logic [DW-1:0] s_a, s_b;
  logic [31:0]   s_res;
  logic [1:0]    s_err;

  int checks   = 0;
  int failures = 0;
  logic [AW-1:0] exp_q[$];

  always #5 clk = ~clk;

  syst_pe #(.DAT_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(KM)) dut (
    .clk(clk), .rst(rst), .i_len(i_len),
    .i_a_vld(i_a_vld), .i_a(i_a), .i_b_vld(i_b_vld), .i_b(i_b),
    .o_a_vld(o_a_vld), .o_a(o_a), .o_b_vld(o_b_vld), .o_b(o_b),
    .o_res_vld(o_res_vld), .o_res(o_res), .i_res_rdy(i_res_rdy),
    .o_err(o_err)
  );

  syst_pe #(.DAT_WIDTH(DW), .ACC_WIDTH(32), .K_MAX(KM)) dut32 (
    .clk(clk), .rst(rst), .i_len(i_len),
    .i_a_vld(i_a_vld), .i_a(i_a), .i_b_vld(i_b_vld), .i_b(i_b),
    .o_a_vld(s_a_vld), .o_a(s_a), .o_b_vld(s_b_vld), .o_b(s_b),
    .o_res_vld(s_res_vld), .o_res(s_res), .i_res_rdy(i_res_rdy),
    .o_err(s_err)
  );

  // Scoreboard: every handshake of the main DUT pops one expected result.
  always @(negedge clk) begin
    if (o_res_vld === 1'b1 && i_res_rdy === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL res_pop unexpected result got=%0d expected=none", $signed(o_res));
      end else begin
        logic [AW-1:0] e;
        e = exp_q.pop_front();
        if (o_res !== e) begin
          failures++;
          $display("FAIL res_pop got=%0d expected=%0d", $signed(o_res), $signed(e));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic va, input logic vb,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
    i_a_vld = va; i_b_vld = vb; i_a = a; i_b = b;
    step();
  endtask

  task automatic idle(input int n);
    i_a_vld = 1'b0; i_b_vld = 1'b0; i_a = '0; i_b = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    i_a_vld = 1'b0; i_b_vld = 1'b0; i_a = '0; i_b = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    i_a_vld = 1'b1; i_b_vld = 1'b1; i_a = 16'h1234; i_b = 16'h4321;
    rst = 1'b1;
    step(); step();
    checks++;
    if ({o_a_vld, o_a, o_b_vld, o_b, o_res_vld, o_res, o_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs a=%h b=%h res_vld=%b res=%h err=%b required all zero",
               o_a, o_b, o_res_vld, o_res, o_err);
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_basic();
    logic [DW-1:0] av[4] = '{16'd1, 16'd2, 16'd3, 16'd4};
    logic [DW-1:0] bv[4] = '{16'd5, 16'd6, 16'd7, 16'd8};
    do_reset();
    i_res_rdy = 1'b1;
    i_len = CW'(4);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(AW'(70));
      drive(1'b1, 1'b1, av[i], bv[i]);
      checks++;
      if (o_a_vld !== 1'b1 || o_a !== av[i] || o_b_vld !== 1'b1 || o_b !== bv[i]) begin
        failures++;
        $display("FAIL basic_fwd beat=%0d got a=%0d/%b b=%0d/%b required a=%0d b=%0d",
                 i, o_a, o_a_vld, o_b, o_b_vld, av[i], bv[i]);
      end
      checks++;
      if (o_res_vld !== (i == 3)) begin
        failures++;
        $display("FAIL basic_res_vld beat=%0d got=%b required=%b", i, o_res_vld, (i == 3));
      end
    end
    idle(1);
    checks++;
    if (o_res_vld !== 1'b0 || o_a_vld !== 1'b0) begin
      failures++;
      $display("FAIL basic_one_cycle got res_vld=%b a_vld=%b required 0 0", o_res_vld, o_a_vld);
    end
  endtask

  task automatic test_signs_gaps();
    do_reset();
    i_res_rdy = 1'b1;
    i_len = CW'(3);
    drive(1'b1, 1'b1, 16'h8000, 16'h8000);
    idle(2);
    checks++;
    if (o_res_vld !== 1'b0) begin
      failures++;
      $display("FAIL gaps_hold got res_vld=%b required 0", o_res_vld);
    end
    drive(1'b1, 1'b1, 16'hFFFF, 16'd5);
    idle(1);
    exp_q.push_back(AW'(1073741798));
    drive(1'b1, 1'b1, 16'd7, 16'hFFFD);
    checks++;
    if (o_res_vld !== 1'b1) begin
      failures++;
      $display("FAIL gaps_done got res_vld=%b required 1", o_res_vld);
    end
    idle(1);
  endtask

  task automatic test_backpressure();
    do_reset();
    i_res_rdy = 1'b0;
    i_len = CW'(1);
    exp_q.push_back(AW'(6));
    drive(1'b1, 1'b1, 16'd2, 16'd3);
    drive(1'b1, 1'b1, 16'd4, 16'd5);
    idle(1);
    checks++;
    if (o_res_vld !== 1'b1 || o_res !== AW'(6) || o_err !== 2'b10) begin
      failures++;
      $display("FAIL ovf_hold got vld=%b res=%0d err=%b required 1 6 10", o_res_vld, o_res, o_err);
    end
    i_res_rdy = 1'b1;
    step();
    checks++;
    if (o_res_vld !== 1'b0) begin
      failures++;
      $display("FAIL ovf_pop got res_vld=%b required 0", o_res_vld);
    end
  endtask

  task automatic test_pop_completion();
    do_reset();
    i_res_rdy = 1'b0;
    i_len = CW'(1);
    exp_q.push_back(AW'(6));
    drive(1'b1, 1'b1, 16'd2, 16'd3);
    idle(1);
    i_res_rdy = 1'b1;
    exp_q.push_back(AW'(20));
    drive(1'b1, 1'b1, 16'd4, 16'd5);
    checks++;
    if (o_res_vld !== 1'b1 || o_res !== AW'(20) || o_err !== 2'b00) begin
      failures++;
      $display("FAIL pop_cmpl got vld=%b res=%0d err=%b required 1 20 00", o_res_vld, o_res, o_err);
    end
    idle(1);
    checks++;
    if (o_res_vld !== 1'b0) begin
      failures++;
      $display("FAIL pop_cmpl_drain got res_vld=%b required 0", o_res_vld);
    end
  endtask

  task automatic test_skew_reset();
    do_reset();
    i_res_rdy = 1'b1;
    i_len = CW'(4);
    drive(1'b1, 1'b1, 16'd2, 16'd3);
    drive(1'b1, 1'b0, 16'd9, 16'd9);
    checks++;
    if (o_err !== 2'b01 || o_res_vld !== 1'b0) begin
      failures++;
      $display("FAIL skew_err got err=%b vld=%b required 01 0", o_err, o_res_vld);
    end
    drive(1'b1, 1'b1, 16'd4, 16'd5);
    drive(1'b1, 1'b1, 16'd1, 16'd1);
    exp_q.push_back(AW'(28));
    drive(1'b1, 1'b1, 16'd1, 16'd1);
    idle(1);
    // abandon a run midway
    drive(1'b1, 1'b1, 16'd3, 16'd3);
    drive(1'b1, 1'b1, 16'd3, 16'd3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checks++;
    if ({o_a_vld, o_a, o_b_vld, o_b, o_res_vld, o_res, o_err} !== '0) begin
      failures++;
      $display("FAIL midrun_reset a=%h b=%h vld=%b res=%h err=%b required all zero",
               o_a, o_b, o_res_vld, o_res, o_err);
    end
    i_len = CW'(2);
    drive(1'b1, 1'b1, 16'd2, 16'd2);
    exp_q.push_back(AW'(13));
    drive(1'b1, 1'b1, 16'd3, 16'd3);
    checks++;
    if (o_res_vld !== 1'b1) begin
      failures++;
      $display("FAIL fresh_run got res_vld=%b required 1", o_res_vld);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    i_res_rdy = 1'b1;
    i_len = CW'(2);
    drive(1'b1, 1'b1, 16'd1, 16'd1);
    exp_q.push_back(AW'(3));
    drive(1'b1, 1'b1, 16'd1, 16'd2);
    drive(1'b1, 1'b1, 16'd2, 16'd2);
    checks++;
    if (o_res_vld !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gap got res_vld=%b required 0", o_res_vld);
    end
    exp_q.push_back(AW'(7));
    drive(1'b1, 1'b1, 16'd3, 16'd1);
    checks++;
    if (o_res_vld !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second got res_vld=%b required 1", o_res_vld);
    end
    idle(1);
  endtask

  task automatic test_len_bounds();
    do_reset();
    i_res_rdy = 1'b1;
    i_len = CW'(0);
    exp_q.push_back(AW'(49));
    drive(1'b1, 1'b1, 16'd7, 16'd7);
    checks++;
    if (o_res_vld !== 1'b1) begin
      failures++;
      $display("FAIL len0 got res_vld=%b required 1", o_res_vld);
    end
    idle(1);
    i_len = CW'(300);
    for (int i = 0; i < KM; i++) begin
      if (i == KM - 1) exp_q.push_back(AW'(KM));
      drive(1'b1, 1'b1, 16'd1, 16'd1);
      if (i == KM - 2 || i == KM - 1) begin
        checks++;
        if (o_res_vld !== (i == KM - 1)) begin
          failures++;
          $display("FAIL len_clamp beat=%0d got res_vld=%b required %b", i, o_res_vld, (i == KM - 1));
        end
      end
    end
    idle(1);
  endtask

  task automatic test_wrap_sat();
    logic [31:0] e32;
`ifdef SYST_PE_SAT_EN
    e32 = 32'h7FFF_FFFF;
`else
    e32 = 32'hC000_0000;
`endif
    do_reset();
    i_res_rdy = 1'b1;
    i_len = CW'(3);
    drive(1'b1, 1'b1, 16'h8000, 16'h8000);
    drive(1'b1, 1'b1, 16'h8000, 16'h8000);
    exp_q.push_back(AW'(64'd3221225472));
    drive(1'b1, 1'b1, 16'h8000, 16'h8000);
    checks++;
    if (s_res_vld !== 1'b1 || s_res !== e32) begin
      failures++;
      $display("FAIL acc32 got vld=%b res=%0d required 1 %0d", s_res_vld, $signed(s_res), $signed(e32));
    end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs_gaps();
    test_backpressure();
    test_pop_completion();
    test_skew_reset();
    test_back_to_back();
    test_len_bounds();
    test_wrap_sat();
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got pending=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_syst_pe
`default_nettype wire

// File: doc/syst_pe.md
Name: syst_pe

Overview:
Output-stationary processing element of the systolic array. It sits directly downstream of the skew shift registers (row skew on A, column skew on B). Each cycle it consumes one valid A/B operand pair and accumulates the signed product over a dot-product of programmable length. It forwards the operands right and down with one cycle of latency, and presents the finished sum on a ready/valid result port.

Parameters:
DAT_WIDTH, 16, width of signed A and B operands
ACC_WIDTH, 40, width of signed accumulator and result; must be >= 2*DAT_WIDTH
K_MAX, 256, maximum dot-product length; CNT_WIDTH = $clog2(K_MAX+1)

Ports:
clk  in  1  clock
rst  in  1  reset
i_len  in  CNT_WIDTH  dot-product length, sampled on the first beat of a run
i_a_vld  in  1  A operand valid (from left / row skew)
i_a  in  DAT_WIDTH  A operand, signed
i_b_vld  in  1  B operand valid (from top / column skew)
i_b  in  DAT_WIDTH  B operand, signed
o_a_vld  out  1  forwarded A valid (to right neighbour)
o_a  out  DAT_WIDTH  forwarded A
o_b_vld  out  1  forwarded B valid (to lower neighbour)
o_b  out  DAT_WIDTH  forwarded B
o_res_vld  out  1  result valid
o_res  out  ACC_WIDTH  result, signed
i_res_rdy  in  1  result consumed when o_res_vld & i_res_rdy
o_err  out  2  sticky errors: [0] skew (valid mismatch), [1] result overflow (dropped)

Interface: one clock, clk. Reset rst is synchronous and active-high.

Behaviour:
- Reset: every register cleared, data included. All outputs read 0. FSM goes to PE_IDLE; accumulator, counter and o_err are 0. Reset mid-run discards the partial sum and any held result.
- Forwarding: o_a/o_a_vld <= i_a/i_a_vld and o_b/o_b_vld <= i_b/i_b_vld every cycle. Latency is 1. Forwarding is unconditional and independent of result backpressure.
- Beat: a beat is i_a_vld & i_b_vld. The product is a full signed DAT_WIDTH x DAT_WIDTH multiply, sign-extended to ACC_WIDTH. Addition wraps modulo 2^ACC_WIDTH.
- Skew error: in any cycle where i_a_vld != i_b_vld, set o_err[0]. No accumulation happens that cycle, and the FSM state is unchanged.
- FSM states: PE_IDLE, PE_ACC.
  - PE_IDLE, on a beat: latch len = (i_len==0 ? 1 : i_len), with i_len > K_MAX clamped to K_MAX. Set acc = product and cnt = 1. If len==1 the run completes this cycle and the FSM stays in PE_IDLE; otherwise go to PE_ACC.
  - PE_ACC, on a beat: acc += product, cnt += 1. When cnt+1 == len the run completes and the FSM returns to PE_IDLE. With no beat, the FSM holds.
- Completion: the final sum (including the current beat) is written to the result register. o_res_vld rises the cycle after the last beat. A beat in the cycle after completion starts a new run with no bubble.
- Result register: o_res_vld is cleared on pop (o_res_vld & i_res_rdy) unless a completion arrives in the same cycle. Pop and completion in the same cycle loads the new sum and keeps o_res_vld = 1.
- Overflow: a completion while o_res_vld=1 and i_res_rdy=0 keeps the old result, drops the new one and sets o_err[1].
- o_err bits clear only on rst.

Optional Feature:
SYST_PE_SAT_EN
- Defined: accumulation saturates to the signed ACC_WIDTH range, i.e. -2^(ACC_WIDTH-1) .. 2^(ACC_WIDTH-1)-1.
- Undefined: accumulation wraps.
- All other behaviour is identical in both cases.

Decomposition:
- Package syst_pkg holds:
  - default DAT_WIDTH / ACC_WIDTH / K_MAX constants
  - typedef enum pe_state_e {PE_IDLE, PE_ACC}
  - error bit indices ERR_SKEW=0, ERR_OVF=1
- Sub-module syst_pe_mac is the natural split: combinational sign-extended multiply-add with the SYST_PE_SAT_EN wrap/saturate selection. It is reused by future weight-stationary variants.

Test Plan:
- Basic run: i_len=4; beats A={1,2,3,4}, B={5,6,7,8} on consecutive cycles, i_res_rdy=1 -> o_res=70, o_res_vld high for 1 cycle, one cycle after the 4th beat. Every beat appears on o_a/o_b one cycle later.
- Signs and gaps: i_len=3; A={-32768,-1,7}, B={-32768,5,-3}, with idle cycles between beats -> o_res=1073741798. The FSM holds in PE_ACC during the gaps.
- Backpressure and overflow: i_len=1; two beats (2*3, then 4*5) with i_res_rdy=0 -> o_res stays 6 and o_err[1]=1. Raising i_res_rdy pops 6, then o_res_vld=0.
- Pop with completion: result 6 held; i_res_rdy=1 in the same cycle a len-1 run 4*5 completes -> next cycle o_res=20, o_res_vld=1, o_err[1]=0.
- Skew and reset: i_a_vld=1, i_b_vld=0 for one cycle -> o_err[0]=1 and the accumulator is unchanged. Then rst mid-run (i_len=4 after 2 beats) -> all outputs 0 and the next run starts fresh.
- Wrap vs saturate: ACC_WIDTH=32, i_len=3, A=B=-32768 each beat -> wraps to -1073741824; with SYST_PE_SAT_EN defined -> 2147483647.
